// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the input debouncer.
// FSM encodings, default qualification length and counter sizing.
package input_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_e;

  localparam int STABLE_CYCLES_DEF = 50000;
  localparam int STABLE_CYCLES_SIM = 4;

  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: 2-flop synchroniser, stability FSM
// and counter, with registered level and edge strobes.
import input_debouncer_pkg::*;

module debounce_channel #(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(STABLE_CYCLES - 1);

  db_state_e       state;
  logic            s1;
  logic            s2;
  logic [CW-1:0]   cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= IDLE_LOW;
      cnt   <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      unique case (state)
        IDLE_LOW: begin
          if (s2) begin
            state <= WAIT_HIGH;
            cnt   <= '0;
          end
        end
        // a revert wins over a terminal count on the same edge
        WAIT_HIGH: begin
          if (!s2) begin
            state <= IDLE_LOW;
            cnt   <= '0;
          end else if (cnt == TERM) begin
            state <= IDLE_HIGH;
            clean <= 1'b1;
            rise  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE_HIGH: begin
          if (!s2) begin
            state <= WAIT_LOW;
            cnt   <= '0;
          end
        end
        WAIT_LOW: begin
          if (s2) begin
            state <= IDLE_HIGH;
            cnt   <= '0;
          end else if (cnt == TERM) begin
            state <= IDLE_LOW;
            clean <= 1'b0;
            fall  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/input_debouncer.sv
// N_CH independent debounced inputs feeding the adder
// operands (bit 0 -> x, bit 1 -> y).
import input_debouncer_pkg::*;

module input_debouncer #(
  parameter int N_CH          = 2,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] clean_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw_in[i]),
      .clean(clean_out[i]),
      .rise (rise_pulse[i]),
      .fall (fall_pulse[i])
    );
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with a 4-cycle
// qualification window.
import input_debouncer_pkg::*;

module tb_input_debouncer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] raw_in = 2'b11;
  logic [1:0] clean_out;
  logic [1:0] rise_pulse;
  logic [1:0] fall_pulse;

  int n_chk = 0;
  int n_err = 0;

  input_debouncer #(
    .N_CH(2),
    .STABLE_CYCLES(STABLE_CYCLES_SIM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (raw_in),
    .clean_out (clean_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag,
                           input logic [1:0] c,
                           input logic [1:0] r,
                           input logic [1:0] f);
    check({tag, ".clean"}, 8'(clean_out), 8'(c));
    check({tag, ".rise"}, 8'(rise_pulse), 8'(r));
    check({tag, ".fall"}, 8'(fall_pulse), 8'(f));
  endtask

  // called right after inputs change; next edge is the sampling edge k
  task automatic qual(input string tag,
                      input logic [1:0] c_old,
                      input logic [1:0] c_new,
                      input logic [1:0] r,
                      input logic [1:0] f);
    repeat (6) tick();
    check_all({tag, ".k5"}, c_old, 2'b00, 2'b00);
    tick();
    check_all({tag, ".k6"}, c_new, r, f);
    tick();
    check_all({tag, ".k7"}, c_new, 2'b00, 2'b00);
  endtask

  task automatic settle(input logic [1:0] v);
    raw_in = v;
    repeat (10) tick();
  endtask

  logic [1:0] acc_c;
  logic [1:0] acc_p;

  initial begin
    // 1: reset with inputs held high
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("rst_hold", 2'b00, 2'b00, 2'b00);
    end
    rst = 1'b0;
    qual("rst_release", 2'b00, 2'b11, 2'b11, 2'b00);

    // release both, exercising the fall path
    raw_in = 2'b00;
    qual("release_both", 2'b11, 2'b00, 2'b00, 2'b11);

    // 2: clean press on channel 0
    raw_in = 2'b01;
    qual("press0", 2'b00, 2'b01, 2'b01, 2'b00);

    // 3: bounce rejection
    settle(2'b00);
    check_all("bounce_pre", 2'b00, 2'b00, 2'b00);
    acc_c = '0;
    acc_p = '0;
    for (int i = 0; i < 20; i++) begin
      raw_in = (i < 8) ? {1'b0, ~i[1]} : 2'b00;
      tick();
      acc_c |= clean_out;
      acc_p |= rise_pulse | fall_pulse;
    end
    check("bounce.clean", 8'(acc_c), 8'd0);
    check("bounce.pulse", 8'(acc_p), 8'd0);

    // 4: s2 reverts exactly on the terminal-count edge
    raw_in = 2'b01;
    repeat (4) tick();
    raw_in = 2'b00;
    acc_c = '0;
    acc_p = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      acc_c |= clean_out;
      acc_p |= rise_pulse | fall_pulse;
    end
    check("tc_glitch.clean", 8'(acc_c), 8'd0);
    check("tc_glitch.pulse", 8'(acc_p), 8'd0);
    // FSM back in IDLE_LOW: a held press takes the full latency
    raw_in = 2'b01;
    qual("after_glitch", 2'b00, 2'b01, 2'b01, 2'b00);

    // 5: opposite transitions on both channels at once
    settle(2'b10);
    check_all("indep_pre", 2'b10, 2'b00, 2'b00);
    raw_in = 2'b01;
    qual("indep", 2'b10, 2'b01, 2'b01, 2'b10);

    // 6: reset while channel 1 is in WAIT_HIGH with cnt=2
    raw_in = 2'b11;
    repeat (5) tick();
    check_all("midwait_pre", 2'b01, 2'b00, 2'b00);
    rst = 1'b1;
    tick();
    check_all("midwait_rst0", 2'b00, 2'b00, 2'b00);
    tick();
    check_all("midwait_rst1", 2'b00, 2'b00, 2'b00);
    rst = 1'b0;
    qual("midwait_requal", 2'b00, 2'b11, 2'b11, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
